// File: rtl/share_collector_if.sv
// Share stream bundle: evaluated-hash input from the zero counter and the
// share output drained by the host with a valid/ready handshake.
interface share_collector_if #(
   parameter int NONCE_W = 32
);
   logic               in_valid;
   logic [NONCE_W-1:0] in_nonce;
   logic [31:0]        in_zeros;
   logic               out_valid;
   logic               out_ready;
   logic [NONCE_W-1:0] out_nonce;
   logic [31:0]        out_zeros;

   modport master (
      output in_valid, in_nonce, in_zeros, out_ready,
      input  out_valid, out_nonce, out_zeros
   );

   modport slave (
      input  in_valid, in_nonce, in_zeros, out_ready,
      output out_valid, out_nonce, out_zeros
   );
endinterface

// File: rtl/share_collector.sv
// Difficulty filter and share FIFO behind the leading-zero counter; also
// tracks the best hash seen plus hash/drop statistics.
module share_collector #(
   parameter int NONCE_W = 32,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst,
   share_collector_if.slave   bus,
   input  logic [31:0]        difficulty_i,
   input  logic               clear_i,
   output logic               best_valid_o,
   output logic [NONCE_W-1:0] best_nonce_o,
   output logic [31:0]        best_zeros_o,
   output logic [63:0]        hash_count_o,
   output logic [31:0]        drop_count_o,
   output logic               full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [NONCE_W-1:0] mem_nonce_q [DEPTH];
   logic [31:0]        mem_zeros_q [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic               best_valid_q, best_valid_d;
   logic [NONCE_W-1:0] best_nonce_q, best_nonce_d;
   logic [31:0]        best_zeros_q, best_zeros_d;
   logic [63:0]        hash_count_q, hash_count_d;
   logic [31:0]        drop_count_q, drop_count_d;

   logic empty_s, full_s, hit_s, pop_s, push_s, best_load_s;

   // Extra pointer MSB distinguishes full from empty when indices match.
   assign empty_s = (wr_ptr_q == rd_ptr_q);
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign hit_s       = bus.in_valid && (bus.in_zeros >= difficulty_i);
   assign pop_s       = !empty_s && bus.out_ready;
   assign push_s      = hit_s && (!full_s || pop_s);
   assign best_load_s = bus.in_valid && (!best_valid_q || (bus.in_zeros > best_zeros_q));

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      best_valid_d = best_valid_q;
      best_nonce_d = best_nonce_q;
      best_zeros_d = best_zeros_q;
      hash_count_d = hash_count_q;
      drop_count_d = drop_count_q;
      if (clear_i) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         best_valid_d = 1'b0;
         best_nonce_d = '0;
         best_zeros_d = 32'd0;
         hash_count_d = 64'd0;
         drop_count_d = 32'd0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         if (bus.in_valid) begin
            hash_count_d = hash_count_q + 64'd1;
         end else begin
            hash_count_d = hash_count_q;
         end
         if (hit_s && !push_s && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_d = drop_count_q + 32'd1;
         end else begin
            drop_count_d = drop_count_q;
         end
         if (best_load_s) begin
            best_valid_d = 1'b1;
            best_nonce_d = bus.in_nonce;
            best_zeros_d = bus.in_zeros;
         end else begin
            best_valid_d = best_valid_q;
         end
      end
   end

   // State registers and FIFO storage; clear blocks the write of that sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         best_valid_q <= 1'b0;
         best_nonce_q <= '0;
         best_zeros_q <= 32'd0;
         hash_count_q <= 64'd0;
         drop_count_q <= 32'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_nonce_q[i] <= '0;
            mem_zeros_q[i] <= 32'd0;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         best_valid_q <= best_valid_d;
         best_nonce_q <= best_nonce_d;
         best_zeros_q <= best_zeros_d;
         hash_count_q <= hash_count_d;
         drop_count_q <= drop_count_d;
         if (push_s && !clear_i) begin
            mem_nonce_q[wr_ptr_q[AW-1:0]] <= bus.in_nonce;
            mem_zeros_q[wr_ptr_q[AW-1:0]] <= bus.in_zeros;
         end
      end
   end

   assign bus.out_valid = !empty_s;
   assign bus.out_nonce = mem_nonce_q[rd_ptr_q[AW-1:0]];
   assign bus.out_zeros = mem_zeros_q[rd_ptr_q[AW-1:0]];
   assign best_valid_o  = best_valid_q;
   assign best_nonce_o  = best_nonce_q;
   assign best_zeros_o  = best_zeros_q;
   assign hash_count_o  = hash_count_q;
   assign drop_count_o  = drop_count_q;
   assign full_o        = full_s;
endmodule

// File: tb/tb_share_collector.sv
// Scoreboard bench for share_collector: expected shares are queued when a hit
// is driven and compared as the DUT hands them out.
module tb_share_collector;
   localparam int NW    = 32;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic [31:0] difficulty_s;
   logic        clear_s;
   logic        best_valid_s;
   logic [NW-1:0] best_nonce_s;
   logic [31:0] best_zeros_s;
   logic [63:0] hash_count_s;
   logic [31:0] drop_count_s;
   logic        full_s;

   share_collector_if #(.NONCE_W(NW)) bus ();

   share_collector #(.NONCE_W(NW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .difficulty_i (difficulty_s),
      .clear_i      (clear_s),
      .best_valid_o (best_valid_s),
      .best_nonce_o (best_nonce_s),
      .best_zeros_o (best_zeros_s),
      .hash_count_o (hash_count_s),
      .drop_count_o (drop_count_s),
      .full_o       (full_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0]   sb_q [$];
   logic [63:0]   m_hash;
   logic [31:0]   m_drop;
   logic          m_best_v;
   logic [NW-1:0] m_best_n;
   logic [31:0]   m_best_z;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_hash   = 64'd0;
      m_drop   = 32'd0;
      m_best_v = 1'b0;
      m_best_n = '0;
      m_best_z = 32'd0;
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, sb_q.size() != 0});
      check_eq({tag, ".full"}, {63'd0, full_s}, {63'd0, sb_q.size() == DEPTH});
      check_eq({tag, ".hash_count"}, hash_count_s, m_hash);
      check_eq({tag, ".drop_count"}, {32'd0, drop_count_s}, {32'd0, m_drop});
      check_eq({tag, ".best_valid"}, {63'd0, best_valid_s}, {63'd0, m_best_v});
      check_eq({tag, ".best_nonce"}, {32'd0, best_nonce_s}, {32'd0, m_best_n});
      check_eq({tag, ".best_zeros"}, {32'd0, best_zeros_s}, {32'd0, m_best_z});
   endtask

   // One clock of stimulus; handshake and model update use pre-edge values.
   task automatic cycle(input logic v, input logic [NW-1:0] n, input logic [31:0] z,
                        input logic rdy, input logic clr);
      logic [63:0] exp;
      bus.in_valid  = v;
      bus.in_nonce  = n;
      bus.in_zeros  = z;
      bus.out_ready = rdy;
      clear_s       = clr;
      #1;
      if (clr) begin
         model_reset();
      end else begin
         if (bus.out_valid && rdy) begin
            if (sb_q.size() == 0) begin
               check_eq("pop_with_empty_model", 64'd1, 64'd0);
            end else begin
               exp = sb_q.pop_front();
               check_eq("head_nonce", {32'd0, bus.out_nonce}, {32'd0, exp[63:32]});
               check_eq("head_zeros", {32'd0, bus.out_zeros}, {32'd0, exp[31:0]});
            end
         end
         if (v) begin
            m_hash = m_hash + 64'd1;
            if (z >= difficulty_s) begin
               if (sb_q.size() < DEPTH) sb_q.push_back({n, z});
               else if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end
            if (!m_best_v || z > m_best_z) begin
               m_best_v = 1'b1;
               m_best_n = n;
               m_best_z = z;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      clear_s      = 1'b0;
      check_state("cyc");
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < budget) begin
         cycle(1'b0, '0, 32'd0, 1'b1, 1'b0);
         k++;
      end
      check_eq("drain_done", {63'd0, bus.out_valid}, 64'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_nonce  = '0;
      bus.in_zeros  = 32'd0;
      bus.out_ready = 1'b0;
      clear_s       = 1'b0;
      difficulty_s  = 32'd0;
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_state("reset");
      cycle(1'b0, '0, 32'd0, 1'b0, 1'b0);

      // Threshold boundary
      difficulty_s = 32'd20;
      cycle(1'b1, 32'h10, 32'd19, 1'b0, 1'b0);
      cycle(1'b1, 32'h11, 32'd20, 1'b0, 1'b0);
      cycle(1'b1, 32'h12, 32'd31, 1'b0, 1'b0);
      check_eq("thr.hash3", hash_count_s, 64'd3);
      check_eq("thr.best_nonce", {32'd0, best_nonce_s}, 64'h12);
      check_eq("thr.head", {32'd0, bus.out_nonce}, 64'h11);
      drain(8);

      // Overflow with consumer stalled
      difficulty_s = 32'd0;
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'h100 + i, 32'd3, 1'b0, 1'b0);
      check_eq("ovf.full", {63'd0, full_s}, 64'd1);
      check_eq("ovf.drop2", {32'd0, drop_count_s}, 64'd2);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 32'd0, 1'b1, 1'b0);
      check_eq("ovf.empty", {63'd0, bus.out_valid}, 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + i, 32'd5, 1'b0, 1'b0);
      cycle(1'b1, 32'h205, 32'd5, 1'b1, 1'b0);
      check_eq("pp.full", {63'd0, full_s}, 64'd1);
      check_eq("pp.nodrop", {32'd0, drop_count_s}, 64'd2);
      drain(8);

      // Best tie keeps earlier nonce, then clear beats same-cycle input
      cycle(1'b0, '0, 32'd0, 1'b0, 1'b1);
      cycle(1'b1, 32'hA, 32'd30, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 32'd30, 1'b0, 1'b0);
      check_eq("tie.best_nonce", {32'd0, best_nonce_s}, 64'hA);
      cycle(1'b1, 32'hC, 32'd40, 1'b1, 1'b1);
      check_eq("clr.best_valid", {63'd0, best_valid_s}, 64'd0);
      check_eq("clr.hash", hash_count_s, 64'd0);
      check_eq("clr.empty", {63'd0, bus.out_valid}, 64'd0);

      // Async reset between edges with two shares queued
      cycle(1'b1, 32'h300, 32'd7, 1'b0, 1'b0);
      cycle(1'b1, 32'h301, 32'd8, 1'b0, 1'b0);
      #3 rst = 1'b1;
      #1;
      check_eq("arst.out_valid", {63'd0, bus.out_valid}, 64'd0);
      check_eq("arst.hash", hash_count_s, 64'd0);
      check_eq("arst.best_valid", {63'd0, best_valid_s}, 64'd0);
      check_eq("arst.full", {63'd0, full_s}, 64'd0);
      #1 rst = 1'b0;
      model_reset();

      // Random streaming after reset
      difficulty_s = 32'd16;
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), 32'h1000 + i, 32'($urandom_range(0, 40)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
      end
      drain(16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
